// File: rtl/alu_iter_ctrl.sv
// Iterative sequencer around the combinational ALU: feeds ALU Out back into InputA
// for a commanded number of cycles to build shift/add/sub/logic-by-N operations.
module alu_iter_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [3:0]        CmdOp,
  input  logic [DATA_W-1:0] CmdA,
  input  logic              CmdB,
  input  logic [CNT_W-1:0]  CmdCount,
  input  logic              Abort,
  output logic [DATA_W-1:0] AluA,
  output logic              AluB,
  output logic [3:0]        AluOp,
  input  logic [DATA_W-1:0] AluOut,
  output logic              ResValid,
  input  logic              ResReady,
  output logic [DATA_W-1:0] Result,
  output logic              ResZero,
  output logic              Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  state_t             state_r;
  state_t             state_s;
  logic [DATA_W-1:0]  acc_r;
  logic [3:0]         op_r;
  logic               b_r;
  logic [CNT_W-1:0]   rem_r;

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; abort beats the final iteration and a pending result
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (CmdValid) begin
          state_s = (CmdCount == CNT_ZERO) ? DONE : RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (Abort) begin
          state_s = IDLE;
        end else if (rem_r == CNT_ONE) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (Abort || ResReady) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Accumulator, operand latches and iteration counter
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      acc_r <= DATA_ZERO;
      op_r  <= 4'd0;
      b_r   <= 1'b0;
      rem_r <= CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (CmdValid) begin
            acc_r <= CmdA;
            op_r  <= CmdOp;
            b_r   <= CmdB;
            rem_r <= CmdCount;
          end
        end
        RUN: begin
          if (!Abort) begin
            acc_r <= AluOut;
            rem_r <= rem_r - CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode; ALU operands are only driven while iterating
  always_comb begin
    CmdReady = 1'b0;
    ResValid = 1'b0;
    Busy     = 1'b0;
    AluA     = DATA_ZERO;
    AluB     = 1'b0;
    AluOp    = 4'd0;
    Result   = acc_r;
    ResZero  = (acc_r == DATA_ZERO);
    case (state_r)
      IDLE: begin
        CmdReady = 1'b1;
      end
      RUN: begin
        Busy  = 1'b1;
        AluA  = acc_r;
        AluB  = b_r;
        AluOp = op_r;
      end
      DONE: begin
        Busy     = 1'b1;
        ResValid = 1'b1;
      end
      default: begin
        CmdReady = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_iter_ctrl.sv
// Bench for alu_iter_ctrl: behavioural ALU plus an iterate-N reference model,
// directed scenarios followed by randomized commands.
module tb_alu_iter_ctrl;

  localparam logic [3:0] K_ADD = 4'h0;
  localparam logic [3:0] K_SUB = 4'h1;
  localparam logic [3:0] K_XOR = 4'h2;
  localparam logic [3:0] K_AND = 4'h3;
  localparam logic [3:0] K_LSH = 4'h4;
  localparam logic [3:0] K_RSH = 4'h5;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       CmdValid = 1'b0;
  logic       CmdReady;
  logic [3:0] CmdOp = 4'd0;
  logic [7:0] CmdA = 8'd0;
  logic       CmdB = 1'b0;
  logic [3:0] CmdCount = 4'd0;
  logic       Abort = 1'b0;
  logic [7:0] AluA;
  logic       AluB;
  logic [3:0] AluOp;
  logic [7:0] AluOut;
  logic       ResValid;
  logic       ResReady = 1'b0;
  logic [7:0] Result;
  logic       ResZero;
  logic       Busy;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  alu_iter_ctrl #(.DATA_W(8), .CNT_W(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdA(CmdA), .CmdB(CmdB), .CmdCount(CmdCount), .Abort(Abort),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluOut(AluOut),
    .ResValid(ResValid), .ResReady(ResReady), .Result(Result), .ResZero(ResZero),
    .Busy(Busy)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic b, input logic [3:0] op);
    case (op)
      K_ADD:   return a + {7'd0, b};
      K_SUB:   return a - {7'd0, b};
      K_XOR:   return a ^ {7'd0, b};
      K_AND:   return a & {7'd0, b};
      K_LSH:   return a << 1;
      K_RSH:   return a >> 1;
      default: return 8'h00;
    endcase
  endfunction

  always_comb AluOut = alu_f(AluA, AluB, AluOp);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // kill_at: RUN cycle index for abort/reset (-1 none); exp_res: plan constant (-1 skip)
  task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic b, input int n,
                         input int kill_at, input bit kill_rst, input int hold,
                         input bit done_abort, input bit noise, input int exp_res);
    logic [7:0] acc;
    int w;
    w = 0;
    while (!CmdReady && w < 50) begin
      step();
      w++;
    end
    check("ready_wait", {31'd0, CmdReady}, 32'd1);
    CmdValid = 1'b1; CmdOp = op; CmdA = a; CmdB = b; CmdCount = n[3:0];
    step();
    CmdValid = 1'b0;
    acc = a;
    for (int i = 0; i < n; i++) begin
      check("run_flags", {29'd0, Busy, CmdReady, ResValid}, 32'b100);
      check("run_alua", {24'd0, AluA}, {24'd0, acc});
      check("run_aluop", {27'd0, AluOp, AluB}, {27'd0, op, b});
      if (noise) begin
        CmdValid = 1'b1; CmdA = 8'($urandom); CmdCount = 4'($urandom); CmdOp = 4'($urandom);
      end
      if (i == kill_at) begin
        if (kill_rst) Reset_n = 1'b0;
        else Abort = 1'b1;
        step();
        Reset_n = 1'b1; Abort = 1'b0; CmdValid = 1'b0;
        check("kill_flags", {29'd0, Busy, CmdReady, ResValid}, 32'b010);
        if (kill_rst) check("rst_result", {23'd0, Result, ResZero}, {23'd0, 8'h00, 1'b1});
        else check("abort_acc", {24'd0, Result}, {24'd0, acc});
        return;
      end
      step();
      acc = alu_f(acc, b, op);
    end
    CmdValid = 1'b0;
    check("done_flags", {29'd0, Busy, CmdReady, ResValid}, 32'b101);
    check("done_result", {24'd0, Result}, {24'd0, acc});
    check("done_zero", {31'd0, ResZero}, {31'd0, (acc == 8'h00)});
    check("done_alu_idle", {19'd0, AluA, AluB, AluOp}, 32'd0);
    if (exp_res >= 0) check("plan_result", {24'd0, Result}, exp_res);
    for (int k = 0; k < hold; k++) begin
      step();
      check("hold_result", {23'd0, ResValid, Result}, {23'd0, 1'b1, acc});
    end
    if (done_abort) Abort = 1'b1;
    else ResReady = 1'b1;
    if (noise) CmdValid = 1'b1;
    step();
    Abort = 1'b0; ResReady = 1'b0; CmdValid = 1'b0;
    check("after_done", {29'd0, Busy, CmdReady, ResValid}, 32'b010);
  endtask

  initial begin
    step();
    step();
    check("rst_flags", {29'd0, Busy, CmdReady, ResValid}, 32'b010);
    check("rst_alu", {19'd0, AluA, AluB, AluOp}, 32'd0);
    check("rst_result", {23'd0, Result, ResZero}, {23'd0, 8'h00, 1'b1});
    Reset_n = 1'b1;
    step();
    check("post_rst_ready", {31'd0, CmdReady}, 32'd1);

    run_cmd(K_LSH, 8'h05, 1'b0, 3, -1, 1'b0, 5, 1'b0, 1'b0, 32'h28);
    run_cmd(K_ADD, 8'hF5, 1'b1, 15, -1, 1'b0, 0, 1'b0, 1'b0, 32'h04);
    run_cmd(K_SUB, 8'h02, 1'b1, 2, -1, 1'b0, 1, 1'b0, 1'b0, 32'h00);
    run_cmd(K_ADD, 8'h7E, 1'b1, 0, -1, 1'b0, 1, 1'b0, 1'b0, 32'h7E);

    Abort = 1'b1;
    step();
    Abort = 1'b0;
    check("idle_abort", {30'd0, Busy, CmdReady}, 32'b01);

    run_cmd(K_RSH, 8'h80, 1'b0, 7, 2, 1'b0, 0, 1'b0, 1'b0, -1);
    run_cmd(K_RSH, 8'h80, 1'b0, 7, -1, 1'b0, 0, 1'b0, 1'b0, 32'h01);
    run_cmd(K_ADD, 8'h10, 1'b1, 8, 3, 1'b1, 0, 1'b0, 1'b0, -1);
    run_cmd(K_XOR, 8'h3C, 1'b1, 3, -1, 1'b0, 0, 1'b0, 1'b0, 32'h3D);
    run_cmd(K_AND, 8'hFF, 1'b1, 1, -1, 1'b0, 0, 1'b1, 1'b0, 32'h01);
    run_cmd(4'hC, 8'hAA, 1'b1, 2, -1, 1'b0, 0, 1'b0, 1'b0, 32'h00);

    for (int t = 0; t < 30; t++) begin
      int n;
      int kill;
      n = int'($urandom_range(0, 15));
      kill = -1;
      if (n > 0 && $urandom_range(0, 3) == 0) kill = int'($urandom_range(0, n - 1));
      run_cmd(4'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), n, kill,
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0), 1'b1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
